// File: rtl/reaction_controller.sv
// Reaction timer control FSM: random pre-delay, stimulus LED, per-ms enable
// pulses into a 3-digit BCD counter, false-start and 999 ms timeout detection.
// Optional macro REACTION_BEST_TIME_EN adds best-time tracking outputs.
module reaction_controller #(
  parameter int unsigned TICK_DIV         = 50000,
  parameter int unsigned MIN_DELAY_MS     = 1000,
  parameter int unsigned DELAY_RANGE_BITS = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_btn,
  input  logic       react_btn,
  input  logic [3:0] bcd0,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd2,
  output logic       bcd_clear,
  output logic       bcd_enable,
  output logic       led,
  output logic       false_start,
  output logic       timeout,
  output logic       busy
`ifdef REACTION_BEST_TIME_EN
  ,
  output logic [3:0] best0,
  output logic [3:0] best1,
  output logic [3:0] best2,
  output logic       new_best
`endif
);

  localparam int unsigned TICK_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DLY_W      = 16;
  localparam int unsigned LFSR_W     = 16;
  localparam int unsigned BCD_W      = 12;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  localparam logic [BCD_W-1:0]  BCD_MAX   = 12'h999;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DELAY  = 3'd1,
    S_TIMING = 3'd2,
    S_DONE   = 3'd3,
    S_FOUL   = 3'd4
  } state_t;

  state_t              state, state_d;
  logic                start_s1, start_s2, start_prev;
  logic                react_s1, react_s2, react_prev;
  logic                start_press_c, react_press_c;
  logic [LFSR_W-1:0]   lfsr;
  logic [TICK_W-1:0]   tick_cnt;
  logic                tick_c, tick_clr_c;
  logic [DLY_W-1:0]    delay_cnt, delay_d, delay_load_c;
  logic                clear_d, enable_d, led_d, fs_d, to_d, busy_d;
  logic                react_done_c;
  logic [BCD_W-1:0]    bcd_val_c;

  assign start_press_c = start_s2 & ~start_prev;
  assign react_press_c = react_s2 & ~react_prev;
  assign tick_c        = (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign delay_load_c  = DLY_W'(MIN_DELAY_MS) + DLY_W'(lfsr[DELAY_RANGE_BITS-1:0]);
  assign bcd_val_c     = {bcd2, bcd1, bcd0};

  // Button synchronisers with edge-detect history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_s1   <= 1'b0;
      start_s2   <= 1'b0;
      start_prev <= 1'b0;
      react_s1   <= 1'b0;
      react_s2   <= 1'b0;
      react_prev <= 1'b0;
    end else begin
      start_s1   <= start_btn;
      start_s2   <= start_s1;
      start_prev <= start_s2;
      react_s1   <= react_btn;
      react_s2   <= react_s1;
      react_prev <= react_s2;
    end
  end

  // Free-running Fibonacci LFSR, taps 16,14,13,11
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[LFSR_W-2:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  // Millisecond tick divider, realigned on entry to DELAY and TIMING
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick_clr_c || tick_c) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      delay_cnt   <= '0;
      bcd_clear   <= 1'b0;
      bcd_enable  <= 1'b0;
      led         <= 1'b0;
      false_start <= 1'b0;
      timeout     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      delay_cnt   <= delay_d;
      bcd_clear   <= clear_d;
      bcd_enable  <= enable_d;
      led         <= led_d;
      false_start <= fs_d;
      timeout     <= to_d;
      busy        <= busy_d;
    end
  end

  // Next-state and next-output decode; react wins over a coincident tick
  always_comb begin
    state_d      = state;
    delay_d      = delay_cnt;
    tick_clr_c   = 1'b0;
    clear_d      = 1'b0;
    enable_d     = 1'b0;
    led_d        = 1'b0;
    fs_d         = false_start;
    to_d         = timeout;
    react_done_c = 1'b0;
    unique case (state)
      S_IDLE, S_DONE, S_FOUL: begin
        if (start_press_c) begin
          state_d    = S_DELAY;
          delay_d    = delay_load_c;
          tick_clr_c = 1'b1;
          clear_d    = 1'b1;
          fs_d       = 1'b0;
          to_d       = 1'b0;
        end
      end
      S_DELAY: begin
        if (react_press_c) begin
          state_d = S_FOUL;
          fs_d    = 1'b1;
        end else if (tick_c) begin
          delay_d = delay_cnt - DLY_W'(1);
          if (delay_cnt <= DLY_W'(1)) begin
            state_d    = S_TIMING;
            led_d      = 1'b1;
            tick_clr_c = 1'b1;
          end
        end
      end
      S_TIMING: begin
        led_d = 1'b1;
        if (react_press_c) begin
          state_d      = S_DONE;
          led_d        = 1'b0;
          react_done_c = 1'b1;
        end else if (tick_c) begin
          if (bcd_val_c == BCD_MAX) begin
            state_d = S_DONE;
            to_d    = 1'b1;
            led_d   = 1'b0;
          end else begin
            enable_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_DELAY) || (state_d == S_TIMING);
  end

`ifdef REACTION_BEST_TIME_EN
  logic capture_pend;

  // Best-time capture one cycle after a react-terminated run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      capture_pend <= 1'b0;
      best0        <= 4'd9;
      best1        <= 4'd9;
      best2        <= 4'd9;
      new_best     <= 1'b0;
    end else begin
      capture_pend <= react_done_c;
      if (capture_pend && (bcd_val_c < {best2, best1, best0})) begin
        best0    <= bcd0;
        best1    <= bcd1;
        best2    <= bcd2;
        new_best <= 1'b1;
      end
      if (clear_d) begin
        new_best <= 1'b0;
      end
    end
  end
`else
  logic unused_react_done;
  assign unused_react_done = react_done_c;
`endif

endmodule

// File: doc/reaction_controller.md
Name: reaction_controller

Overview:
- Control FSM that sits directly upstream of the 3-digit BCD millisecond counter in the reaction timer.
- On a start press it waits a pseudo-random delay, then lights the stimulus LED and emits one bcd_enable pulse per millisecond until the react press.
- Generates bcd_clear for the counter, detects false starts and 999 ms timeout, and reads the counter digits back for the timeout check.

Parameters:
- TICK_DIV, 50000, clk cycles per 1 ms tick (50 MHz clock); must be >= 2
- MIN_DELAY_MS, 1000, fixed part of the random wait, in ms
- DELAY_RANGE_BITS, 11, random part of the wait = LFSR low bits, range 0..2^bits-1 ms

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start_btn  in  1  start button, asynchronous, active-high level
- react_btn  in  1  reaction button, asynchronous, active-high level
- bcd0  in  4  counter ones digit
- bcd1  in  4  counter tens digit
- bcd2  in  4  counter hundreds digit
- bcd_clear  out  1  registered, drives counter clear
- bcd_enable  out  1  registered, drives counter enable; one-cycle pulse per ms
- led  out  1  stimulus LED
- false_start  out  1  react pressed before LED
- timeout  out  1  count reached 999 without reaction
- busy  out  1  high in DELAY or TIMING

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; tick counter 0; delay counter 0; synchronisers 0; LFSR=16'hACE1.
- Buttons: 2-flop synchroniser plus previous-value flop; press = sync2 & ~prev. A level held high produces exactly one press.
- State changes on the 3rd rising edge after the input is first sampled high.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Free-runs every cycle in all states.
- Tick counter: counts 0..TICK_DIV-1 and wraps. tick=1 for the cycle when count==TICK_DIV-1. Forced to 0 on entry to DELAY and on entry to TIMING.
- States: IDLE, DELAY, TIMING, DONE, FOUL.
- IDLE/DONE/FOUL + start press -> DELAY:
  - delay_cnt <= MIN_DELAY_MS + LFSR[DELAY_RANGE_BITS-1:0]; delay_cnt is 16 bits, and the sum must fit.
  - bcd_clear=1 for exactly that one cycle.
  - false_start <= 0, timeout <= 0.
- DELAY:
  - Each tick decrements delay_cnt.
  - When tick and delay_cnt==1 -> TIMING, led <= 1.
  - React press -> FOUL, false_start <= 1, led stays 0. React wins over a simultaneous tick.
  - Start press is ignored.
- TIMING:
  - bcd_enable <= tick; the first pulse comes TICK_DIV cycles after entry.
  - React press -> DONE, led <= 0, no enable pulse in that cycle; react wins over a simultaneous tick.
  - If tick and {bcd2,bcd1,bcd0}==999 -> DONE, timeout <= 1, led <= 0, no enable, so the counter holds 999.
  - Start press is ignored.
- DONE/FOUL: hold flags; led=0, bcd_enable=0; the counter holds the result. React press is ignored.
- busy = (state==DELAY)|(state==TIMING), registered.
- Reset asserted mid-run returns to IDLE immediately; led drops asynchronously.

Optional Feature:
- Macro: REACTION_BEST_TIME_EN.
- When defined:
  - Adds outputs best0/best1/best2 (4 bits each) and new_best (1 bit), all reset to 9,9,9 and 0.
  - On TIMING->DONE via react press, the {bcd2,bcd1,bcd0} value at the cycle after transition is compared against best. If strictly lower, best is updated and new_best=1 until the next start press.
  - Timeout and FOUL never update best.
- When undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset/power-up: rst_n=0 for 3 cycles -> all outputs 0; after release with no presses, state stays IDLE and bcd_enable is never asserted.
- Normal run (TICK_DIV=4, MIN_DELAY_MS=2, DELAY_RANGE_BITS=2):
  - Start press -> one-cycle bcd_clear.
  - led rises after 4*(2..5) cycles.
  - bcd_enable pulses every 4 cycles.
  - React after 7 pulses with a behavioural BCD model attached -> DONE, led=0, counter reads 007, no further pulses.
- False start: react press during DELAY -> FOUL, false_start=1, led never rises, no bcd_enable; a following start press clears false_start and re-enters DELAY.
- Timeout: no react; the model counts to 999 -> on the next tick, DONE with timeout=1, no 1000th pulse, counter holds 999.
- Boundary and glitch cases:
  - React press landing in the same cycle as a tick -> no enable pulse that cycle.
  - Start held high for 100 cycles -> only one run.
  - rst_n pulled low mid-TIMING -> led=0 immediately, state IDLE.
- With REACTION_BEST_TIME_EN: runs of 050, 030, 040 ms -> best=030, new_best high after 2nd run, low after 3rd.
